// File: rtl/mov_ext_unit.sv
// mov_ext_unit: two-stage move/extend pipeline.
// S1 captures the request; S2 forms the zero/sign-extended or merged result.
// LastOut tracks the most recent result so that merge modes can chain.
module mov_ext_unit #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             MovValid,
    output logic             MovReady,
    input  logic [1:0]       MovOp,
    input  logic [IN_W-1:0]  MovIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [OUT_W-1:0] MovOut
);

    typedef enum logic [1:0] {
        MODE_ZEXT = 2'b00,
        MODE_SEXT = 2'b01,
        MODE_LDHI = 2'b10,
        MODE_LDLO = 2'b11
    } movMode_t;

    logic             s1Valid;
    movMode_t         s1Op;
    logic [IN_W-1:0]  s1In;
    logic [OUT_W-1:0] lastOut;
    logic [OUT_W-1:0] nextOut;
    logic             s2Free;
    logic             accept;
    logic             advance;

    assign s2Free   = !OutValid || OutReady;
    assign MovReady = !s1Valid || s2Free;
    assign accept   = MovValid && MovReady;
    assign advance  = s1Valid && s2Free;

    // Stage 1: capture the request; hold while S2 is stalled.
    // MovReady is exactly "S1 empty or draining", so it gates the valid update.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1Valid <= 1'b0;
            s1Op    <= MODE_ZEXT;
            s1In    <= '0;
        end else begin
            if (MovReady) begin
                s1Valid <= accept;
            end
            if (accept) begin
                s1Op <= movMode_t'(MovOp);
                s1In <= MovIn;
            end
        end
    end

    // Result formation from the S1 operand and the last produced result.
    // Overlaying the operand onto a base value keeps every mode free of
    // zero-width slices when OUT_W == IN_W.
    always_comb begin
        nextOut = '0;
        unique case (s1Op)
            MODE_ZEXT: begin
                nextOut             = '0;
                nextOut[IN_W-1:0]   = s1In;
            end
            MODE_SEXT: begin
                nextOut             = {OUT_W{s1In[IN_W-1]}};
                nextOut[IN_W-1:0]   = s1In;
            end
            MODE_LDHI: begin
                nextOut                  = lastOut;
                nextOut[OUT_W-1 -: IN_W] = s1In;
            end
            MODE_LDLO: begin
                nextOut             = lastOut;
                nextOut[IN_W-1:0]   = s1In;
            end
        endcase
    end

    // Stage 2: register the result and its valid; hold while stalled.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            OutValid <= 1'b0;
            MovOut   <= '0;
            lastOut  <= '0;
        end else begin
            if (s2Free) begin
                OutValid <= s1Valid;
            end
            if (advance) begin
                MovOut  <= nextOut;
                lastOut <= nextOut;
            end
        end
    end

endmodule

// File: tb/tb_mov_ext_unit.sv
// tb_mov_ext_unit: directed and random checks of mov_ext_unit against a
// sequence-level reference model (results in acceptance order, merges read
// the previous result).
`timescale 1ns/1ps
module tb_mov_ext_unit;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;

    logic        clk;
    logic        rstN;
    logic        movValid, movReady, outValid, outReady;
    logic [1:0]  movOp;
    logic [7:0]  movIn;
    logic [15:0] movOut;

    logic        mov8Valid, mov8Ready, out8Valid, out8Ready;
    logic [1:0]  mov8Op;
    logic [7:0]  mov8In;
    logic [7:0]  mov8Out;

    int vectors;
    int miscompares;

    logic [15:0] expQ[$];
    logic [15:0] modelLast;

    mov_ext_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .Clk(clk), .Rst_n(rstN),
        .MovValid(movValid), .MovReady(movReady),
        .MovOp(movOp), .MovIn(movIn),
        .OutValid(outValid), .OutReady(outReady),
        .MovOut(movOut)
    );

    mov_ext_unit #(.IN_W(8), .OUT_W(8)) dut8 (
        .Clk(clk), .Rst_n(rstN),
        .MovValid(mov8Valid), .MovReady(mov8Ready),
        .MovOp(mov8Op), .MovIn(mov8In),
        .OutValid(out8Valid), .OutReady(out8Ready),
        .MovOut(mov8Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result computed arithmetically for the default widths.
    function automatic logic [15:0] refResult(input logic [1:0] op, input logic [7:0] in,
                                               input logic [15:0] last);
        longint unsigned v       = longint'(in);
        longint unsigned lv      = longint'(last);
        longint unsigned hiScale = 64'd1 << (OUT_W - IN_W);
        longint unsigned loScale = 64'd1 << IN_W;
        longint unsigned full    = 64'd1 << OUT_W;
        longint unsigned r;
        case (op)
            2'b00:   r = v;
            2'b01:   r = (v >= loScale / 2) ? v + full - loScale : v;
            2'b10:   r = v * hiScale + (lv % hiScale);
            default: r = (lv / loScale) * loScale + v;
        endcase
        return r[15:0];
    endfunction

    // Reset discards everything in flight and the merge history.
    always @(negedge rstN) begin
        expQ.delete();
        modelLast = '0;
    end

    // Compare process: inputs are stable mid-cycle, so the handshakes seen
    // here are the ones the next rising edge will act on.
    always @(negedge clk) begin
        if (rstN) begin
            if (outValid) begin
                if (expQ.size() == 0) begin
                    check("spurious OutValid", 32'(outValid), 32'd0);
                end else begin
                    check("model MovOut", 32'(movOut), 32'(expQ[0]));
                    if (outReady) void'(expQ.pop_front());
                end
            end
            if (movValid && movReady) begin
                logic [15:0] r;
                r = refResult(movOp, movIn, modelLast);
                expQ.push_back(r);
                modelLast = r;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [7:0] in);
        check("MovReady on offer", 32'(movReady), 32'd1);
        movValid = 1'b1;
        movOp    = op;
        movIn    = in;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        modelLast   = '0;
        rstN        = 1'b0;
        movValid    = 1'b0;
        movOp       = 2'b00;
        movIn       = '0;
        outReady    = 1'b1;
        mov8Valid   = 1'b0;
        mov8Op      = 2'b00;
        mov8In      = '0;
        out8Ready   = 1'b1;
        repeat (3) @(posedge clk);
        #2 rstN = 1'b1;
        step();

        // Reset state
        check("reset MovReady", 32'(movReady), 32'd1);
        check("reset OutValid", 32'(outValid), 32'd0);
        check("reset MovOut", 32'(movOut), 32'h0);

        // Extend modes, then a chained merge sequence
        offer(2'b01, 8'hFF); step();
        check("latency OutValid low", 32'(outValid), 32'd0);
        offer(2'b00, 8'hFF); step();
        check("sext FF", 32'(movOut), 32'hFFFF);
        check("sext valid", 32'(outValid), 32'd1);
        offer(2'b01, 8'h01); step();
        check("zext FF", 32'(movOut), 32'h00FF);
        offer(2'b10, 8'hAB); step();
        check("sext 01", 32'(movOut), 32'h0001);
        offer(2'b11, 8'hCD); step();
        check("load-high AB", 32'(movOut), 32'hAB01);
        movValid = 1'b0; step();
        check("load-low CD", 32'(movOut), 32'hABCD);
        step();
        check("pipe empty", 32'(outValid), 32'd0);

        // Backpressure: two buffered, third waits
        outReady = 1'b0;
        offer(2'b00, 8'h11); step();
        offer(2'b00, 8'h22); step();
        movOp = 2'b10; movIn = 8'h33;
        check("full MovReady low", 32'(movReady), 32'd0);
        step();
        check("stall MovReady low", 32'(movReady), 32'd0);
        check("stall hold value", 32'(movOut), 32'h0011);
        check("stall hold valid", 32'(outValid), 32'd1);
        outReady = 1'b1; #1;
        check("MovReady rises with OutReady", 32'(movReady), 32'd1);
        step();
        check("drain second", 32'(movOut), 32'h0022);
        movValid = 1'b0; step();
        check("drain third merged", 32'(movOut), 32'h3322);
        step();
        check("drain done", 32'(outValid), 32'd0);

        // Asynchronous reset with two requests in flight
        offer(2'b00, 8'h44); step();
        offer(2'b00, 8'h55); step();
        movValid = 1'b0;
        #1 rstN = 1'b0;
        #1;
        check("async reset OutValid", 32'(outValid), 32'd0);
        check("async reset MovOut", 32'(movOut), 32'h0);
        check("async reset MovReady", 32'(movReady), 32'd1);
        rstN = 1'b1;
        step();
        check("no resurrected result", 32'(outValid), 32'd0);
        offer(2'b10, 8'h12); step();
        movValid = 1'b0; step();
        check("post-reset merge", 32'(movOut), 32'h1200);
        step();

        // Equal widths: every mode passes the operand through
        for (int m = 0; m < 4; m++) begin
            mov8Valid = 1'b1;
            mov8Op    = 2'(m);
            mov8In    = 8'h9C;
            step();
            mov8Valid = 1'b0;
            step();
            check("equal-width valid", 32'(out8Valid), 32'd1);
            check("equal-width MovOut", 32'(mov8Out), 32'h9C);
        end

        // Random traffic, checked by the compare process every cycle
        for (int c = 0; c < 10000; c++) begin
            movValid = 1'($urandom_range(0, 1));
            movOp    = 2'($urandom_range(0, 3));
            movIn    = 8'($urandom_range(0, 255));
            outReady = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain with a bounded wait
        movValid = 1'b0;
        outReady = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (expQ.size() == 0 && !outValid) break;
            step();
        end
        check("drain queue empty", 32'(expQ.size()), 32'd0);
        check("drain OutValid low", 32'(outValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mov_ext_unit.md
MOV_EXT_UNIT -- requirements
Module: mov_ext_unit

Interface
REQ-001 SHALL have parameter IN_W, default 8, meaning source operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter OUT_W, default 16, meaning result width in bits; legal range IN_W..2*IN_W.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port MovValid  input  1  request present on MovOp/MovIn.
REQ-006 SHALL have port MovReady  output  1  unit accepts a request this cycle.
REQ-007 SHALL have port MovOp  input  2  mode: 00 zero-extend, 01 sign-extend, 10 load-high merge, 11 load-low merge.
REQ-008 SHALL have port MovIn  input  IN_W  source operand.
REQ-009 SHALL have port OutValid  output  1  MovOut holds a valid result.
REQ-010 SHALL have port OutReady  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port MovOut  output  OUT_W  result, registered.

Function
REQ-012 SHALL be a 2-stage pipeline: S1 registers MovOp/MovIn; S2 computes and registers MovOut/OutValid.
REQ-013 SHALL transfer a request on Clk edge when MovValid && MovReady (accept); a result is consumed when OutValid && OutReady.
REQ-014 SHALL drive S2Free = !OutValid || OutReady, and MovReady = !S1Valid || S2Free (combinational, no dependency on MovValid).
REQ-015 SHALL move S1 into S2 when S1Valid && S2Free; S1Valid then takes the accept value of the same edge.
REQ-016 SHALL give latency of exactly 2 cycles from accept to OutValid with OutReady held high; throughput 1 per cycle.
REQ-017 SHALL hold MovOut, OutValid stable while OutValid && !OutReady; S1 holds its contents while S2 is stalled.
REQ-018 SHALL keep register LastOut (OUT_W), updated with every result entering S2; merge modes read LastOut at S1->S2 transfer, so back-to-back merges chain without bubbles.
REQ-019 Mode 00 SHALL produce {(OUT_W-IN_W) zeros, MovIn}.
REQ-020 Mode 01 SHALL produce MovIn with bit IN_W-1 replicated into the upper OUT_W-IN_W bits.
REQ-021 Mode 10 SHALL produce MovIn in bits [OUT_W-1:OUT_W-IN_W], LastOut in the remaining low bits.
REQ-022 Mode 11 SHALL produce MovIn in bits [IN_W-1:0], LastOut in the remaining high bits.
REQ-023 When OUT_W == IN_W, all modes SHALL produce MovIn unmodified.
REQ-024 Simultaneous accept, S1->S2 transfer and consume in one cycle SHALL all take effect with no loss or duplication.
REQ-025 Inputs SHALL be ignored (no state change) when MovValid is low or MovReady is low.
REQ-026 With OutReady low and both stages full, MovReady SHALL be low; exactly 2 results are buffered.

Reset
REQ-027 Rst_n low SHALL immediately clear S1Valid, OutValid, MovOut and LastOut to 0, independent of Clk.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight requests; none reappear after release.
REQ-029 MovReady SHALL be 1 in the first cycle after Rst_n deasserts.

Verification
REQ-030 Defaults, OutReady=1: accept MovOp=01, MovIn=8'hFF -> 2 cycles later OutValid=1, MovOut=16'hFFFF; MovOp=00 same input -> 16'h00FF.
REQ-031 Defaults: MovOp=01 MovIn=8'h01 -> 16'h0001; then back-to-back MovOp=10 MovIn=8'hAB, MovOp=11 MovIn=8'hCD -> 16'hAB01 then 16'hABCD on consecutive cycles.
REQ-032 Defaults: hold OutReady=0, offer 3 requests -> 2 accepted, MovReady=0 on the third; raise OutReady -> results in order, third accepted the same cycle MovReady rises, none lost.
REQ-033 Defaults: two requests in flight, pulse Rst_n low between edges -> OutValid and MovOut fall at once; after release, first new result with MovOp=10 MovIn=8'h12 -> 16'h1200.
REQ-034 IN_W=8, OUT_W=8: each of modes 00-11 with MovIn=8'h9C -> MovOut=8'h9C.
REQ-035 Random valid/ready stimulus with a reference model over >=10000 cycles -> every accepted request produces exactly one matching result, in order.
